seq_scan_ctrl: RTL and testbench

Controller that sequences a serial Mealy pattern detector over parallel data words. On a start handshake it latches a WIDTH-bit word and feeds it bit-serially, MSB first, into an embedded overlapping pattern detector, one bit per clock. It counts matches and records the index of the first match, then pulses done. It sits between a word-oriented producer and the bit-serial detector datapath.

---
 rtl/seq_pkg.sv | 14 +
 rtl/seq_pat_det.sv | 58 +++++
 rtl/seq_scan_ctrl.sv | 100 ++++++++++
 tb/tb_seq_scan_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern scanner.
// This file holds the state encoding and the default detector pattern.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int                  DEF_PLEN = 4;
    localparam logic [DEF_PLEN-1:0] DEF_PAT  = 4'b1001;

endpackage

// File: rtl/seq_pat_det.sv
// Overlapping Mealy pattern detector. The state is the length of the matched prefix.
// Transitions come from a KMP table that is built at elaboration.
module seq_pat_det #(
    parameter int              PLEN = 4,
    parameter logic [PLEN-1:0] PAT  = 4'b1001
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic x,
    output logic z
);

    localparam int QW = $clog2(PLEN);

    logic [QW-1:0] q;
    logic [QW-1:0] nxt_tab [2*PLEN];
    logic          hit;

    // Returns the longest proper prefix of PAT that is also a suffix of
    // (matched prefix of length qs) followed by bit xb.
    function automatic int kmp_next(input int qs, input int xb);
        int   best;
        int   i;
        logic ok;
        logic sb;
        best = 0;
        for (int k = PLEN - 1; k >= 1; k--) begin
            if (best == 0 && k <= qs + 1) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    i  = qs + 1 - k + j;
                    sb = (i == qs) ? (xb != 0) : PAT[PLEN-1-i];
                    if (sb != PAT[PLEN-1-j]) ok = 1'b0;
                end
                if (ok) best = k;
            end
        end
        return best;
    endfunction

    for (genvar g = 0; g < 2*PLEN; g++) begin : g_tab
        assign nxt_tab[g] = QW'(kmp_next(g / 2, g % 2));
    end

    assign hit = (q == QW'(PLEN - 1)) && (x == PAT[0]);
    assign z   = en & hit;

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            q <= '0;
        end else if (en) begin
            q <= nxt_tab[{q, x}];
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Latches a word and feeds it MSB-first into the pattern detector, one bit per clock.
// It counts the matches, captures the position of the first match and pulses done.
module seq_scan_ctrl
    import seq_pkg::*;
#(
    parameter int              WIDTH = 16,
    parameter int              PLEN  = DEF_PLEN,
    parameter logic [PLEN-1:0] PAT   = DEF_PAT,
    parameter int              CNT_W = $clog2(WIDTH + 1),
    parameter int              POS_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             x_ser,
    output logic             z_det,
    output logic [CNT_W-1:0] match_cnt,
    output logic [POS_W-1:0] first_pos,
    output logic             first_valid,
    output logic             done
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [POS_W-1:0] idx;
    logic             accept;
    logic             shifting;
    logic             last;

    assign accept   = (state == IDLE) && start;
    assign shifting = (state == SHIFT);
    assign last     = (idx == POS_W'(WIDTH - 1));

    assign busy  = (state == SHIFT) || (state == DONE);
    assign done  = (state == DONE);
    assign x_ser = shifting & sreg[WIDTH-1];

    seq_pat_det #(
        .PLEN (PLEN),
        .PAT  (PAT)
    ) u_det (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .en    (shifting),
        .x     (x_ser),
        .z     (z_det)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // abort takes priority over the last-bit transition, so a match on the final bit is not counted.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT: begin
                if (abort)     state_nxt = IDLE;
                else if (last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sreg        <= '0;
            idx         <= '0;
            match_cnt   <= '0;
            first_pos   <= '0;
            first_valid <= 1'b0;
        end else if (accept) begin
            sreg        <= data_in;
            idx         <= '0;
            match_cnt   <= '0;
            first_pos   <= '0;
            first_valid <= 1'b0;
        end else if (shifting && abort) begin
            sreg <= '0;
        end else if (shifting) begin
            sreg <= {sreg[WIDTH-2:0], 1'b0};
            idx  <= idx + POS_W'(1);
            if (z_det) begin
                match_cnt <= match_cnt + CNT_W'(1);
                if (!first_valid) begin
                    first_pos   <= idx;
                    first_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: a table of scanned words plus hand-written
// sequences for held start, abort, start+abort and reset in the middle of a scan.
module tb_seq_scan_ctrl;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;
    localparam int POS_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             busy;
    logic             x_ser;
    logic             z_det;
    logic [CNT_W-1:0] match_cnt;
    logic [POS_W-1:0] first_pos;
    logic             first_valid;
    logic             done;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [15:0] data;
        logic [15:0] zmask;
        int          cnt;
        int          pos;
        logic        valid;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    seq_scan_ctrl #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .data_in     (data_in),
        .busy        (busy),
        .x_ser       (x_ser),
        .z_det       (z_det),
        .match_cnt   (match_cnt),
        .first_pos   (first_pos),
        .first_valid (first_valid),
        .done        (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (done) seen = 1'b1;
            else tick();
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [15:0] zobs;
        logic [15:0] xobs;
        logic        early;
        zobs    = '0;
        xobs    = '0;
        early   = 1'b0;
        data_in = v.data;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        chk({tag, " busy"}, busy, 1);
        for (int k = 0; k < WIDTH; k++) begin
            zobs[k]      = z_det;
            xobs[15 - k] = x_ser;
            if (done) early = 1'b1;
            tick();
        end
        chk({tag, " z_trace"}, zobs, v.zmask);
        chk({tag, " x_trace"}, xobs, v.data);
        chk({tag, " early_done"}, early, 0);
        chk({tag, " done"}, done, 1);
        chk({tag, " match_cnt"}, match_cnt, v.cnt);
        chk({tag, " first_pos"}, first_pos, v.pos);
        chk({tag, " first_valid"}, first_valid, v.valid);
        tick();
        chk({tag, " done_drop"}, done, 0);
        chk({tag, " busy_drop"}, busy, 0);
        chk({tag, " cnt_hold"}, match_cnt, v.cnt);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   seen;
        logic early;

        vecs[0] = '{16'h9249, 16'h9248, 5, 3,  1'b1};
        vecs[1] = '{16'h0000, 16'h0000, 0, 0,  1'b0};
        vecs[2] = '{16'h0004, 16'h0000, 0, 0,  1'b0};
        vecs[3] = '{16'h8000, 16'h0000, 0, 0,  1'b0};
        vecs[4] = '{16'h9999, 16'h8888, 4, 3,  1'b1};
        vecs[5] = '{16'h1200, 16'h0040, 1, 6,  1'b1};
        vecs[6] = '{16'h0009, 16'h8000, 1, 15, 1'b1};
        vecs[7] = '{16'hFFFF, 16'h0000, 0, 0,  1'b0};

        reset = 1'b0;
        tick();
        tick();
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst x_ser", x_ser, 0);
        chk("rst z_det", z_det, 0);
        chk("rst match_cnt", match_cnt, 0);
        chk("rst first_pos", first_pos, 0);
        chk("rst first_valid", first_valid, 0);
        reset = 1'b1;
        tick();
        chk("idle busy", busy, 0);

        // Consecutive entries run back to back, so 0004 followed by 8000 probes the word boundary.
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Held start: data_in changes mid-scan and must not disturb the latched word.
        data_in = 16'h9249;
        start   = 1'b1;
        tick();
        for (int k = 0; k < WIDTH; k++) begin
            if (k == 5) data_in = 16'hFFFF;
            tick();
        end
        chk("held done", done, 1);
        chk("held match_cnt", match_cnt, 5);
        chk("held first_pos", first_pos, 3);
        tick();
        chk("held idle busy", busy, 0);
        chk("held idle done", done, 0);
        tick();
        chk("held restart busy", busy, 1);
        chk("held restart cnt", match_cnt, 0);
        start = 1'b0;
        wait_done(20, seen);
        chk("held second done", seen, 1);
        chk("held second cnt", match_cnt, 0);
        chk("held second valid", first_valid, 0);
        tick();

        // Abort at k=8 keeps the partial results.
        data_in = 16'h9249;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort match_cnt", match_cnt, 2);
        chk("abort first_pos", first_pos, 3);
        chk("abort first_valid", first_valid, 1);
        early = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done || busy) early = 1'b1;
            tick();
        end
        chk("abort no_done", early, 0);

        // Abort on the last bit: that bit's match is presented but not counted.
        data_in = 16'h0009;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 15; k++) tick();
        chk("abort_last z_det", z_det, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_last busy", busy, 0);
        chk("abort_last done", done, 0);
        chk("abort_last cnt", match_cnt, 0);
        chk("abort_last valid", first_valid, 0);

        // Start and abort together in IDLE: the start is taken.
        data_in = 16'h0009;
        start   = 1'b1;
        abort   = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort busy", busy, 1);
        wait_done(20, seen);
        chk("start_abort done", seen, 1);
        chk("start_abort cnt", match_cnt, 1);
        chk("start_abort pos", first_pos, 15);
        tick();

        // Reset in the middle of a scan, followed by a fresh scan.
        data_in = 16'h9249;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst cnt", match_cnt, 0);
        chk("midrst valid", first_valid, 0);
        chk("midrst pos", first_pos, 0);
        chk("midrst x_ser", x_ser, 0);
        run_vec('{16'h9000, 16'h0008, 1, 3, 1'b1}, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
